// File: rtl/display_transition_sequencer_if.sv
// rtl/display_transition_sequencer_if.sv - CPU and display peripheral bus bundle for the transition sequencer
interface display_transition_sequencer_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data_in;
    logic        cpu_wren;
    logic        cpu_rden;
    logic [31:0] cpu_data_out;
    logic        cpu_stall;
    logic [31:0] per_addr;
    logic [31:0] per_data_in;
    logic        per_wren;
    logic        per_rden;
    logic [31:0] per_data_out;
    logic        busy;

    // master: the sequencer itself (serves the CPU, drives the peripheral)
    modport master (
        input  cpu_addr, cpu_data_in, cpu_wren, cpu_rden, per_data_out,
        output cpu_data_out, cpu_stall, per_addr, per_data_in, per_wren, per_rden, busy
    );

    // slave: the surrounding system (CPU and peripheral models)
    modport slave (
        output cpu_addr, cpu_data_in, cpu_wren, cpu_rden, per_data_out,
        input  cpu_data_out, cpu_stall, per_addr, per_data_in, per_wren, per_rden, busy
    );
endinterface

// File: rtl/display_transition_sequencer.sv
// rtl/display_transition_sequencer.sv - intercepts display mode changes and fades brightness around them
// Optional status register at BASE_ADDR+0x1C enabled by DISP_SEQ_STATUS_EN.
module display_transition_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF1000,
    parameter int          STEP        = 8,
    parameter int          STEP_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    display_transition_sequencer_if.master bus
);

    localparam logic [31:0] MODE_ADDR   = BASE_ADDR;
    localparam logic [31:0] BRI_ADDR    = BASE_ADDR + 32'h4;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'h1C;
    localparam int          TW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD    = TW'(STEP_CYCLES - 1);
    localparam logic [7:0]  STEP_B      = 8'(STEP);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    state_t        state;
    logic          cur_mode;
    logic          pend_mode;
    logic [7:0]    cur_bri;
    logic [7:0]    tgt_bri;
    logic [TW-1:0] timer;
    logic          seq_wren;
    logic [31:0]   seq_addr;
    logic [31:0]   seq_data;

    logic          idle;
    logic          mode_hit;
    logic          bri_hit;
    logic          status_hit;
    logic          mode_change;
    logic [7:0]    bri_down;
    logic [8:0]    bri_sum;
    logic [7:0]    bri_up;

    always_comb begin
        idle        = (state == IDLE);
        mode_hit    = (bus.cpu_addr == MODE_ADDR);
        bri_hit     = (bus.cpu_addr == BRI_ADDR);
`ifdef DISP_SEQ_STATUS_EN
        status_hit  = (bus.cpu_addr == STATUS_ADDR);
`else
        status_hit  = 1'b0;
`endif
        mode_change = bus.cpu_wren && mode_hit && (bus.cpu_data_in[0] != cur_mode);
        bri_down    = (cur_bri > STEP_B) ? (cur_bri - STEP_B) : 8'd0;
        bri_sum     = {1'b0, cur_bri} + {1'b0, STEP_B};
        bri_up      = (bri_sum > {1'b0, tgt_bri}) ? tgt_bri : bri_sum[7:0];
    end

    // Bus steering: CPU passthrough in IDLE, sequencer-owned peripheral bus otherwise
    always_comb begin
        bus.busy         = !idle;
        bus.cpu_data_out = 32'h0;
        if (idle) begin
            bus.per_addr    = bus.cpu_addr;
            bus.per_data_in = bus.cpu_data_in;
            bus.per_wren    = bus.cpu_wren && !mode_change && !status_hit;
            bus.per_rden    = bus.cpu_rden && !status_hit;
            bus.cpu_stall   = 1'b0;
            if (bus.cpu_rden && !status_hit)
                bus.cpu_data_out = bus.per_data_out;
        end else begin
            bus.per_addr    = seq_addr;
            bus.per_data_in = seq_data;
            bus.per_wren    = seq_wren;
            bus.per_rden    = 1'b0;
            bus.cpu_stall   = (bus.cpu_wren || bus.cpu_rden) && !status_hit;
        end
`ifdef DISP_SEQ_STATUS_EN
        if (status_hit && bus.cpu_rden)
            bus.cpu_data_out = {16'h0, cur_bri, 7'h0, !idle};
`endif
    end

    // A fade step's write is visible the cycle after it is computed, so the exit
    // test on cur_bri runs while that final write is still on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_mode  <= 1'b0;
            pend_mode <= 1'b0;
            cur_bri   <= 8'd255;
            tgt_bri   <= 8'd255;
            timer     <= '0;
            seq_wren  <= 1'b0;
            seq_addr  <= 32'h0;
            seq_data  <= 32'h0;
        end else begin
            seq_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_wren && bri_hit) begin
                        cur_bri <= bus.cpu_data_in[7:0];
                        tgt_bri <= bus.cpu_data_in[7:0];
                    end
                    if (mode_change) begin
                        pend_mode <= bus.cpu_data_in[0];
                        timer     <= RELOAD;
                        if (cur_bri == 8'd0) begin
                            state    <= SWITCH;
                            seq_wren <= 1'b1;
                            seq_addr <= MODE_ADDR;
                            seq_data <= {31'h0, bus.cpu_data_in[0]};
                        end else begin
                            state <= FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (cur_bri == 8'd0) begin
                        state    <= SWITCH;
                        seq_wren <= 1'b1;
                        seq_addr <= MODE_ADDR;
                        seq_data <= {31'h0, pend_mode};
                    end else if (timer == '0) begin
                        cur_bri  <= bri_down;
                        seq_wren <= 1'b1;
                        seq_addr <= BRI_ADDR;
                        seq_data <= {24'h0, bri_down};
                        timer    <= RELOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SWITCH: begin
                    cur_mode <= pend_mode;
                    timer    <= RELOAD;
                    state    <= (tgt_bri == 8'd0) ? IDLE : FADE_IN;
                end
                FADE_IN: begin
                    if (cur_bri == tgt_bri) begin
                        state <= IDLE;
                    end else if (timer == '0) begin
                        cur_bri  <= bri_up;
                        seq_wren <= 1'b1;
                        seq_addr <= BRI_ADDR;
                        seq_data <= {24'h0, bri_up};
                        timer    <= RELOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
